davinci_fifoout_stage: RTL and testbench

//   Output stage between the vvtile_array parallel port and the FIFO-out. Captures
//   the vector stream (data + status attributes) and buffers it in a small circular

---
 rtl/davinci_fifoout_pkg.sv | 14 +
 rtl/davinci_fifoout_stage_if.sv | 29 ++
 rtl/davinci_skid_queue.sv | 57 +++++
 rtl/davinci_fifoout_stage.sv | 100 ++++++++++
 tb/tb_davinci_fifoout_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/davinci_fifoout_pkg.sv
// Shared definitions for the FIFO-out stage and the davinci interface: attribute
// bit positions and the packed attribute view.
package davinci_fifoout_pkg;

  localparam int ATTR_VALID_BIT = 0;
  localparam int ATTR_EOV_BIT   = 1;

  // Field order follows the bit positions above: valid is bit 0, eov is bit 1.
  typedef struct packed {
    logic eov;
    logic valid;
  } attrib_t;

endpackage

// File: rtl/davinci_fifoout_stage_if.sv
// Bus bundle between vvtile_array, the FIFO-out stage and FIFO-out.
// The slave side is the stage itself; the master side is its environment.
interface davinci_fifoout_stage_if #(
  parameter int DATAOUT_WIDTH = 16,
  parameter int ATTRIB_WIDTH  = 2,
  parameter int LEN_WIDTH     = 12
);
  logic [DATAOUT_WIDTH-1:0] parallelIn;
  logic [ATTRIB_WIDTH-1:0]  parStatusIn;
  logic                     srcReady;
  logic                     fifoFull;
  logic [DATAOUT_WIDTH-1:0] dataout;
  logic [ATTRIB_WIDTH-1:0]  dataAttrib;
  logic                     dataoutValid;
  logic                     eovInterrupt;
  logic                     clearEOV;
  logic [LEN_WIDTH-1:0]     vecLen;
  logic                     overflow;

  modport master (
    output parallelIn, parStatusIn, fifoFull, clearEOV,
    input  srcReady, dataout, dataAttrib, dataoutValid, eovInterrupt, vecLen, overflow
  );

  modport slave (
    input  parallelIn, parStatusIn, fifoFull, clearEOV,
    output srcReady, dataout, dataAttrib, dataoutValid, eovInterrupt, vecLen, overflow
  );
endinterface

// File: rtl/davinci_skid_queue.sv
// Small circular queue with a separate occupancy count. A push into a full queue
// is accepted only when a pop frees the head slot on the same edge.
module davinci_skid_queue #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ce,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    nextCount,
  output logic             full,
  output logic             empty,
  output logic             popped
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rdPtr, wrPtr;
  logic [CW-1:0]               count;
  logic                        accept;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign popped = ce && pop && !empty;
  assign accept = ce && push && (!full || popped);
  assign rdata  = mem[rdPtr];

  always_comb begin
    nextCount = count;
    case ({accept, popped})
      2'b10:   nextCount = count + CW'(1);
      2'b01:   nextCount = count - CW'(1);
      default: nextCount = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (accept) wrPtr <= wrPtr + PW'(1);
      if (popped) rdPtr <= rdPtr + PW'(1);
      count <= nextCount;
    end
  end

  // Storage needs no reset; the count alone decides what is live.
  always_ff @(posedge clk) begin
    if (rstn && accept) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/davinci_fifoout_stage.sv
// Output stage from the vvtile_array parallel port into FIFO-out: skid queue,
// output register, vector-length counter, sticky EOV/overflow and srcReady.
module davinci_fifoout_stage
  import davinci_fifoout_pkg::*;
#(
  parameter int DEBUG         = 0,
  parameter int DATAOUT_WIDTH = 16,
  parameter int ATTRIB_WIDTH  = 2,
  parameter int BUF_DEPTH     = 4,
  parameter int READY_SLACK   = 2,
  parameter int LEN_WIDTH     = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic dbg_clk_enable,
  davinci_fifoout_stage_if.slave bus
);
  localparam int EW = DATAOUT_WIDTH + ATTRIB_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic                     ce;
  logic                     inValid;
  logic [EW-1:0]            headElem;
  logic [DATAOUT_WIDTH-1:0] headData;
  logic [ATTRIB_WIDTH-1:0]  headAttrib;
  logic                     headEov;
  logic [CW-1:0]            nextCount;
  logic                     qFull, qEmpty, popped, drop;

  logic [DATAOUT_WIDTH-1:0] doutReg;
  logic [ATTRIB_WIDTH-1:0]  attrReg;
  logic                     vldReg, eovReg, ovfReg, rdyReg;
  logic [LEN_WIDTH-1:0]     vecLenReg, elemCnt, cntInc;

  assign ce      = (DEBUG != 0) ? dbg_clk_enable : 1'b1;
  assign inValid = bus.parStatusIn[ATTR_VALID_BIT];

  davinci_skid_queue #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) uQueue (
    .clk       (clk),
    .rstn      (rstn),
    .ce        (ce),
    .push      (inValid),
    .pop       (!bus.fifoFull && !qEmpty),
    .wdata     ({bus.parStatusIn, bus.parallelIn}),
    .rdata     (headElem),
    .nextCount (nextCount),
    .full      (qFull),
    .empty     (qEmpty),
    .popped    (popped)
  );

  assign headData   = headElem[DATAOUT_WIDTH-1:0];
  assign headAttrib = headElem[EW-1:DATAOUT_WIDTH];
  assign headEov    = headAttrib[ATTR_EOV_BIT];
  assign drop       = ce && inValid && qFull && !popped;
  // Saturating increment so an oversized vector reports all-ones, not a wrapped length.
  assign cntInc     = (&elemCnt) ? elemCnt : elemCnt + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      doutReg   <= '0;
      attrReg   <= '0;
      vldReg    <= 1'b0;
      eovReg    <= 1'b0;
      vecLenReg <= '0;
      elemCnt   <= '0;
      ovfReg    <= 1'b0;
      rdyReg    <= 1'b1;
    end else if (ce) begin
      vldReg <= popped;
      if (popped) begin
        doutReg <= headData;
        attrReg <= headAttrib;
        if (headEov) begin
          vecLenReg <= cntInc;
          elemCnt   <= '0;
        end else begin
          elemCnt <= cntInc;
        end
      end
      // Set beats clear when both land on the same edge.
      if (popped && headEov)  eovReg <= 1'b1;
      else if (bus.clearEOV)  eovReg <= 1'b0;
      if (drop) ovfReg <= 1'b1;
      rdyReg <= (nextCount <= CW'(BUF_DEPTH - READY_SLACK));
    end
  end

  // Masking with ce keeps a held strobe from being seen again on a stalled debug cycle.
  assign bus.dataoutValid = vldReg && ce;
  assign bus.dataout      = doutReg;
  assign bus.dataAttrib   = attrReg;
  assign bus.eovInterrupt = eovReg;
  assign bus.vecLen       = vecLenReg;
  assign bus.overflow     = ovfReg;
  assign bus.srcReady     = rdyReg;
endmodule

// File: tb/tb_davinci_fifoout_stage.sv
// Bench for davinci_fifoout_stage: directed scenarios plus a random phase, all
// compared against a queue-based reference model; a DEBUG=1 instance rides along.
module tb_davinci_fifoout_stage;
  import davinci_fifoout_pkg::*;

  localparam int DW = 16, AW = 2, LW = 12, DEPTH = 4, SLACK = 2;
  localparam int LMAX = (1 << LW) - 1;

  typedef struct packed {
    logic [DW-1:0] d;
    attrib_t       a;
  } elem_t;

  logic clk = 1'b0, rstn = 1'b0, dbg1 = 1'b1;
  logic [DW-1:0] inData = '0;
  attrib_t inSt = '0;
  logic full = 1'b0, clr = 1'b0;
  bit chk1 = 1'b1;
  int nAssert = 0, nFail = 0;

  always #5 clk = ~clk;

  davinci_fifoout_stage_if #(.DATAOUT_WIDTH(DW), .ATTRIB_WIDTH(AW), .LEN_WIDTH(LW)) bus0 ();
  davinci_fifoout_stage_if #(.DATAOUT_WIDTH(DW), .ATTRIB_WIDTH(AW), .LEN_WIDTH(LW)) bus1 ();

  assign bus0.parallelIn = inData;  assign bus1.parallelIn = inData;
  assign bus0.parStatusIn = inSt;   assign bus1.parStatusIn = inSt;
  assign bus0.fifoFull = full;      assign bus1.fifoFull = full;
  assign bus0.clearEOV = clr;       assign bus1.clearEOV = clr;

  davinci_fifoout_stage #(.DEBUG(0), .DATAOUT_WIDTH(DW), .ATTRIB_WIDTH(AW), .BUF_DEPTH(DEPTH),
    .READY_SLACK(SLACK), .LEN_WIDTH(LW)) dut0 (
    .clk(clk), .rstn(rstn), .dbg_clk_enable(1'b0), .bus(bus0.slave));

  davinci_fifoout_stage #(.DEBUG(1), .DATAOUT_WIDTH(DW), .ATTRIB_WIDTH(AW), .BUF_DEPTH(DEPTH),
    .READY_SLACK(SLACK), .LEN_WIDTH(LW)) dut1 (
    .clk(clk), .rstn(rstn), .dbg_clk_enable(dbg1), .bus(bus1.slave));

  // Reference model state (always-enabled stage).
  elem_t q[$];
  logic [DW-1:0] mDout;
  attrib_t mAttr;
  logic mVld, mEov, mOvf, mRdy;
  int mLen, mCnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit doPop, acc;
    elem_t h;
    h = '0;
    if (!rstn) begin
      q.delete();
      mDout = '0; mAttr = '0; mVld = 0; mEov = 0; mLen = 0; mCnt = 0; mOvf = 0; mRdy = 1;
    end else begin
      doPop = (q.size() > 0) && !full;
      acc = inSt.valid && ((q.size() < DEPTH) || doPop);
      if (doPop) begin
        h = q.pop_front();
        mDout = h.d;
        mAttr = h.a;
        if (h.a.eov) begin
          mLen = (mCnt + 1 > LMAX) ? LMAX : mCnt + 1;
          mCnt = 0;
        end else begin
          mCnt = (mCnt + 1 > LMAX) ? LMAX : mCnt + 1;
        end
      end
      if (doPop && h.a.eov) mEov = 1;
      else if (clr) mEov = 0;
      mVld = doPop;
      if (inSt.valid && !acc) mOvf = 1;
      if (acc) q.push_back({inData, inSt});
      mRdy = (q.size() <= DEPTH - SLACK);
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    chk("valid0", bus0.dataoutValid, mVld);
    chk("dout0", bus0.dataout, mDout);
    chk("attr0", bus0.dataAttrib, mAttr);
    chk("eov0", bus0.eovInterrupt, mEov);
    chk("veclen0", bus0.vecLen, mLen);
    chk("ovf0", bus0.overflow, mOvf);
    chk("rdy0", bus0.srcReady, mRdy);
    if (chk1) begin
      chk("valid1", bus1.dataoutValid, mVld);
      chk("dout1", bus1.dataout, mDout);
      chk("eov1", bus1.eovInterrupt, mEov);
      chk("veclen1", bus1.vecLen, mLen);
      chk("ovf1", bus1.overflow, mOvf);
      chk("rdy1", bus1.srcReady, mRdy);
    end
  endtask

  task automatic drive(logic v, logic e, logic [DW-1:0] d);
    inSt.valid = v;
    inSt.eov   = e;
    inData     = d;
  endtask

  task automatic doReset();
    rstn = 0; drive(0, 0, '0); full = 0; clr = 0;
    step(); step();
    rstn = 1;
  endtask

  initial begin
    int writes;
    logic [DW-1:0] expD;

    // 1) reset state, then a 3-element vector
    doReset();
    chk("rst_valid", bus0.dataoutValid, 0);
    chk("rst_rdy", bus0.srcReady, 1);
    chk("rst_veclen", bus0.vecLen, 0);
    drive(1, 0, 16'h0011); step();
    chk("t1_lat1", bus0.dataoutValid, 0);
    drive(1, 0, 16'h0022); step();
    chk("t1_d1", bus0.dataout, 16'h0011);
    drive(1, 1, 16'h0033); step();
    chk("t1_d2", bus0.dataout, 16'h0022);
    drive(0, 0, '0); step();
    chk("t1_d3", bus0.dataout, 16'h0033);
    chk("t1_eov", bus0.eovInterrupt, 1);
    chk("t1_len", bus0.vecLen, 3);
    step();
    chk("t1_idle", bus0.dataoutValid, 0);

    // 2) backpressure with 6 arrivals into a 4-deep queue
    full = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, DW'(16'h0100 + i)); step();
      if (i == 1) chk("t2_rdy_hi", bus0.srcReady, 1);
      if (i == 2) chk("t2_rdy_lo", bus0.srcReady, 0);
      if (i == 3) chk("t2_noovf", bus0.overflow, 0);
    end
    chk("t2_ovf", bus0.overflow, 1);
    drive(0, 0, '0); full = 0;
    writes = 0; expD = 16'h0100;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus0.dataoutValid) begin
        chk("t2_order", bus0.dataout, expD);
        expD++; writes++;
      end
    end
    chk("t2_writes", writes, 4);

    // 3) clear colliding with an EOV write
    clr = 1; step(); clr = 0;
    chk("t3_clr", bus0.eovInterrupt, 0);
    drive(1, 1, 16'h0AAA); step();
    drive(0, 0, '0); clr = 1; step();
    chk("t3_setwins", bus0.eovInterrupt, 1);
    step(); clr = 0;
    chk("t3_clr2", bus0.eovInterrupt, 0);

    // 4) full queue with push+pop, across pointer wrap
    doReset();
    full = 1;
    for (int i = 0; i < 4; i++) begin drive(1, 0, DW'(16'h0200 + i)); step(); end
    full = 0; expD = 16'h0200; writes = 0;
    for (int i = 4; i < 10; i++) begin
      drive(1, 0, DW'(16'h0200 + i)); step();
      chk("t4_order", bus0.dataout, expD); expD++; writes++;
      chk("t4_rdy", bus0.srcReady, 0);
    end
    drive(0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus0.dataoutValid) begin chk("t4_drain", bus0.dataout, expD); expD++; writes++; end
    end
    chk("t4_writes", writes, 10);
    chk("t4_ovf", bus0.overflow, 0);

    // 5) reset with elements queued
    full = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 0, DW'(16'h0300 + i)); step(); end
    drive(0, 0, '0); full = 0; rstn = 0; step(); rstn = 1;
    chk("t5_valid", bus0.dataoutValid, 0);
    chk("t5_rdy", bus0.srcReady, 1);
    drive(1, 0, 16'h0401); step();
    drive(1, 1, 16'h0402); step();
    drive(0, 0, '0); step(); step(); step();
    chk("t5_len", bus0.vecLen, 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) < 7, ($urandom % 5) == 0, DW'($urandom));
      full = ($urandom % 10) < 3;
      clr  = ($urandom % 10) == 0;
      rstn = ($urandom % 64) != 0;
      step();
    end
    rstn = 1;

    // vecLen saturation on an oversized vector
    doReset();
    for (int i = 0; i < LMAX + 5; i++) begin drive(1, 0, DW'(i)); step(); end
    drive(1, 1, 16'hBEEF); step();
    drive(0, 0, '0); step(); step();
    chk("sat_len", bus0.vecLen, LMAX);

    // 6) debug stepping on the DEBUG=1 instance
    doReset();
    chk1 = 0;
    dbg1 = 1; drive(1, 0, 16'h0555); step();
    chk("t6_e1", bus1.dataoutValid, 0);
    dbg1 = 0; drive(1, 1, 16'h0666); step();
    chk("t6_e2", bus1.dataoutValid, 0);
    dbg1 = 1; drive(0, 0, '0); step();
    chk("t6_e3v", bus1.dataoutValid, 1);
    chk("t6_e3d", bus1.dataout, 16'h0555);
    dbg1 = 0; step();
    chk("t6_e4v", bus1.dataoutValid, 0);
    chk("t6_e4d", bus1.dataout, 16'h0555);
    dbg1 = 1; step();
    chk("t6_e5v", bus1.dataoutValid, 0);
    chk("t6_e5eov", bus1.eovInterrupt, 0);
    chk("t6_e5ovf", bus1.overflow, 0);
    chk("t6_e5rdy", bus1.srcReady, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
